if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage_pkg.sv | 11 +
 rtl/if_nextpc_sel.sv | 20 ++
 rtl/if_fetch_stage.sv | 95 +++++++++
 tb/tb_if_fetch_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline widths and the reset fetch address used by every stage.
package if_fetch_stage_pkg;

    localparam int          FS_TO_DS_WD = 64;
    localparam int          BR_TO_FS_WD = 33;
    localparam logic [31:0] RESET_PC    = 32'h1C00_0000;

    // fs_pc sits one word behind RESET_PC so the sequential path lands on it
    localparam logic [31:0] FS_PC_RESET = RESET_PC - 32'd4;

endpackage

// File: rtl/if_nextpc_sel.sv
// Next fetch address: live redirect, then a parked redirect, then fs_pc + 4.
module if_nextpc_sel (
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_pending,
    input  logic [31:0] br_pending_target,
    input  logic [31:0] fs_pc,
    output logic [31:0] nextpc
);

    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pending) begin
            nextpc = br_pending_target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Two-phase instruction fetch (pre-IF issues the SRAM read, IF holds pc/valid).
// Define IF_INST_BUF_EN to add a one-entry buffer that keeps the instruction across decode stalls.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ds_allow_in,
    input  logic [BR_TO_FS_WD-1:0] br_bus,
    output logic                   fs_to_ds_valid,
    output logic [FS_TO_DS_WD-1:0] fs_to_ds_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_we,
    output logic [31:0]            inst_sram_addr,
    input  logic [31:0]            inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allow_in;
    logic        br_pending;
    logic [31:0] br_pending_target;
    logic [31:0] nextpc;
    logic [31:0] inst;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    assign fs_ready_go = 1'b1;
    assign fs_allow_in = !fs_valid || (fs_ready_go && ds_allow_in);

    if_nextpc_sel u_nextpc_sel (
        .br_taken          (br_taken),
        .br_target         (br_target),
        .br_pending        (br_pending),
        .br_pending_target (br_pending_target),
        .fs_pc             (fs_pc),
        .nextpc            (nextpc)
    );

    assign inst_sram_en   = !rst && fs_allow_in;
    assign inst_sram_we   = 4'b0000;
    assign inst_sram_addr = nextpc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_valid          <= 1'b0;
            fs_pc             <= FS_PC_RESET;
            br_pending        <= 1'b0;
            br_pending_target <= 32'd0;
        end else begin
            if (fs_allow_in) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end
            // A redirect seen while IF is stalled is parked until the slot frees up
            if (fs_allow_in) begin
                br_pending <= 1'b0;
            end else if (br_taken) begin
                br_pending        <= 1'b1;
                br_pending_target <= br_target;
            end
        end
    end

`ifdef IF_INST_BUF_EN
    logic        inst_buf_valid;
    logic [31:0] inst_buf;

    // Clearing on any refill of IF (not only on handshake) keeps a wrong-path
    // capture from leaking into the redirected fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'd0;
        end else if (br_taken || fs_allow_in) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid && !ds_allow_in && !inst_buf_valid && !br_pending) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

    assign inst = inst_buf_valid ? inst_buf : inst_sram_rdata;
`else
    assign inst = inst_sram_rdata;
`endif

    assign fs_to_ds_valid = fs_valid && !br_taken && !br_pending && fs_ready_go;
    assign fs_to_ds_bus   = {fs_pc, inst};

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage; SRAM model returns addr ^ 32'hA5A50000.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        ds_allow_in;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        corrupt;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ds_allow_in     (ds_allow_in),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM that holds its output while not enabled
    always @(posedge clk) begin
        if (inst_sram_en) begin
            inst_sram_rdata <= inst_sram_addr ^ 32'hA5A5_0000;
        end else if (corrupt) begin
            inst_sram_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, apply inputs, let combinational outputs settle
    task automatic cyc(input logic r, input logic allow, input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        rst         = r;
        ds_allow_in = allow;
        br_bus      = {bt, tgt};
        #1;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                           input logic vld, input logic [63:0] bus);
        chk({tag, ".en"},   inst_sram_en,   en);
        chk({tag, ".we"},   inst_sram_we,   4'b0000);
        if (en) chk({tag, ".addr"}, inst_sram_addr, addr);
        chk({tag, ".vld"},  fs_to_ds_valid, vld);
        if (vld) chk({tag, ".bus"}, fs_to_ds_bus, bus);
    endtask

    initial begin
        rst         = 1'b1;
        ds_allow_in = 1'b1;
        br_bus      = '0;
        corrupt     = 1'b0;

        // Reset held
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk_out("rst", 0, 0, 0, 0);
        chk("rst.addr", inst_sram_addr, 32'h1C00_0000);

        // Reset release: sequential fetch
        cyc(0, 1, 0, 0);
        chk_out("seq0", 1, 32'h1C00_0000, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("seq1", 1, 32'h1C00_0004, 1, {32'h1C00_0000, 32'hB9A5_0000});
        cyc(0, 1, 0, 0);
        chk_out("seq2", 1, 32'h1C00_0008, 1, {32'h1C00_0004, 32'hB9A5_0004});

        // Redirect with decode ready: IF slot dropped, immediate target fetch
        cyc(0, 1, 1, 32'h1C00_0100);
        chk_out("br", 1, 32'h1C00_0100, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("br.tgt", 1, 32'h1C00_0104, 1, {32'h1C00_0100, 32'hB9A5_0100});

        // Redirect during a 3-cycle stall: parked as pending
        cyc(0, 0, 1, 32'h1C00_0200);
        chk_out("pend0", 0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_out("pend1", 0, 0, 0, 0);
        chk("pend1.flag", dut.br_pending, 1'b1);
        cyc(0, 0, 0, 0);
        chk_out("pend2", 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("pend.rel", 1, 32'h1C00_0200, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("pend.tgt", 1, 32'h1C00_0204, 1, {32'h1C00_0200, 32'hB9A5_0200});
        chk("pend.clr", dut.br_pending, 1'b0);

        // 4-cycle stall; SRAM output overwritten mid-stall when buffered
        for (int i = 0; i < 4; i++) begin
`ifdef IF_INST_BUF_EN
            corrupt = (i == 1);
`endif
            cyc(0, 0, 0, 0);
            chk_out("stall", 0, 0, 1, {32'h1C00_0204, 32'hB9A5_0204});
        end
        corrupt = 1'b0;
        cyc(0, 1, 0, 0);
        chk_out("stall.rel", 1, 32'h1C00_0208, 1, {32'h1C00_0204, 32'hB9A5_0204});
        cyc(0, 1, 0, 0);
        chk_out("stall.next", 1, 32'h1C00_020C, 1, {32'h1C00_0208, 32'hB9A5_0208});

        // br_taken held two cycles: newest target wins
        cyc(0, 1, 1, 32'h1C00_0400);
        chk_out("hold0", 1, 32'h1C00_0400, 0, 0);
        cyc(0, 1, 1, 32'h1C00_0500);
        chk_out("hold1", 1, 32'h1C00_0500, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("hold.tgt", 1, 32'h1C00_0504, 1, {32'h1C00_0500, 32'hB9A5_0500});

        // Reset during a stall with a pending redirect
        cyc(0, 0, 1, 32'h1C00_0300);
        cyc(0, 0, 0, 0);
        chk("rp.flag", dut.br_pending, 1'b1);
        cyc(1, 0, 0, 0);
        chk_out("rp.rst", 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("rp.rel", 1, 32'h1C00_0000, 0, 0);
        chk("rp.clr", dut.br_pending, 1'b0);
        cyc(0, 1, 0, 0);
        chk_out("rp.seq", 1, 32'h1C00_0004, 1, {32'h1C00_0000, 32'hB9A5_0000});

        // Address wrap at the top of the space
        cyc(0, 1, 1, 32'hFFFF_FFFC);
        chk_out("wrap.br", 1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 1, 0, 0);
        chk_out("wrap", 1, 32'h0000_0000, 1, {32'hFFFF_FFFC, 32'h5A5A_FFFC});
        cyc(0, 1, 0, 0);
        chk_out("wrap.next", 1, 32'h0000_0004, 1, {32'h0000_0000, 32'hA5A5_0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
